// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: control FSM states
// and the operand forwarding select codes.
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_MC_BUSY = 2'b01
    } ctrl_state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    // True when a pipeline writer targets the given source register.
    function automatic logic writer_hits(input logic valid, input logic wr_en,
                                         input logic [7:0] rd_addr,
                                         input logic [7:0] src_addr);
        return valid && wr_en && (rd_addr == src_addr);
    endfunction

endpackage

// File: rtl/fwd_sel.sv
// Forwarding select for one ALU operand: the younger MEM-stage writer wins
// over the WB-stage writer; register 0 is not special.
module fwd_sel
    import hazard_pkg::*;
#(
    parameter int REG_AW = 4
) (
    input  logic [REG_AW-1:0] src_addr,
    input  logic              mem_valid,
    input  logic              mem_wr_en,
    input  logic [REG_AW-1:0] mem_rd_addr,
    input  logic              wb_valid,
    input  logic              wb_wr_en,
    input  logic [REG_AW-1:0] wb_rd_addr,
    output logic [1:0]        sel
);

    logic [7:0] src_w;
    logic [7:0] mem_w;
    logic [7:0] wb_w;

    assign src_w = 8'(src_addr);
    assign mem_w = 8'(mem_rd_addr);
    assign wb_w  = 8'(wb_rd_addr);

    always_comb begin
        sel = FWD_RF;
        if (writer_hits(mem_valid, mem_wr_en, mem_w, src_w)) begin
            sel = FWD_MEM;
        end else if (writer_hits(wb_valid, wb_wr_en, wb_w, src_w)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, EX flush, multi-cycle EX hold
// and operand forwarding selects. Only the FSM state and hold counter are flops.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW = 4,
    parameter int MC_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic              id_uses_rq,
    input  logic              id_uses_rs,
    input  logic [REG_AW-1:0] id_rq_addr,
    input  logic [REG_AW-1:0] id_rs_addr,
    input  logic              ex_valid,
    input  logic              ex_wr_en,
    input  logic              ex_is_load,
    input  logic [REG_AW-1:0] ex_rd_addr,
    input  logic              ex_flush,
    input  logic              ex_mc_start,
    input  logic [MC_W-1:0]   ex_mc_len,
    input  logic              mem_valid,
    input  logic              mem_wr_en,
    input  logic [REG_AW-1:0] mem_rd_addr,
    input  logic              wb_valid,
    input  logic              wb_wr_en,
    input  logic [REG_AW-1:0] wb_rd_addr,
    output logic              pc_stall,
    output logic              if_id_stall,
    output logic              id_ex_bubble,
    output logic              if_id_flush,
    output logic              ex_hold,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic [1:0]        ctrl_state
);

    ctrl_state_e     state_q, state_d;
    logic [MC_W-1:0] cnt_q, cnt_d;
    logic            load_use;
    logic [1:0]      fwd_a_raw;
    logic [1:0]      fwd_b_raw;

    assign load_use = id_valid && ex_valid && ex_is_load && ex_wr_en &&
                      ((id_uses_rq && (id_rq_addr == ex_rd_addr)) ||
                       (id_uses_rs && (id_rs_addr == ex_rd_addr)));

    // Counter holds the number of hold cycles still to serve, including the current one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (ex_mc_start && !ex_flush && (ex_mc_len != '0)) begin
                    state_d = ST_MC_BUSY;
                    cnt_d   = ex_mc_len;
                end
            end
            ST_MC_BUSY: begin
                cnt_d = cnt_q - MC_W'(1);
                if (cnt_q == MC_W'(1)) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Flush outranks load-use; neither is looked at while a multi-cycle op holds EX.
    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        ex_hold      = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_RUN: begin
                    if (ex_flush) begin
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                    end else if (load_use) begin
                        pc_stall     = 1'b1;
                        if_id_stall  = 1'b1;
                        id_ex_bubble = 1'b1;
                    end
                end
                ST_MC_BUSY: begin
                    ex_hold     = 1'b1;
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                end
                default: begin
                    pc_stall = 1'b0;
                end
            endcase
        end
    end

    fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
        .src_addr   (id_rq_addr),
        .mem_valid  (mem_valid),
        .mem_wr_en  (mem_wr_en),
        .mem_rd_addr(mem_rd_addr),
        .wb_valid   (wb_valid),
        .wb_wr_en   (wb_wr_en),
        .wb_rd_addr (wb_rd_addr),
        .sel        (fwd_a_raw)
    );

    fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
        .src_addr   (id_rs_addr),
        .mem_valid  (mem_valid),
        .mem_wr_en  (mem_wr_en),
        .mem_rd_addr(mem_rd_addr),
        .wb_valid   (wb_valid),
        .wb_wr_en   (wb_wr_en),
        .wb_rd_addr (wb_rd_addr),
        .sel        (fwd_b_raw)
    );

    assign fwd_a_sel  = rst ? FWD_RF : fwd_a_raw;
    assign fwd_b_sel  = rst ? FWD_RF : fwd_b_raw;
    assign ctrl_state = rst ? 2'b00 : 2'(state_q);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus random traffic compared
// cycle by cycle against a remaining-hold-cycles reference model.
module tb_hazard_ctrl;

    localparam int REG_AW = 4;
    localparam int MC_W   = 4;

    logic              clk;
    logic              rst;
    logic              id_valid, id_uses_rq, id_uses_rs;
    logic [REG_AW-1:0] id_rq_addr, id_rs_addr;
    logic              ex_valid, ex_wr_en, ex_is_load;
    logic [REG_AW-1:0] ex_rd_addr;
    logic              ex_flush, ex_mc_start;
    logic [MC_W-1:0]   ex_mc_len;
    logic              mem_valid, mem_wr_en;
    logic [REG_AW-1:0] mem_rd_addr;
    logic              wb_valid, wb_wr_en;
    logic [REG_AW-1:0] wb_rd_addr;
    logic              pc_stall, if_id_stall, id_ex_bubble, if_id_flush, ex_hold;
    logic [1:0]        fwd_a_sel, fwd_b_sel, ctrl_state;

    int n_checks;
    int n_fail;
    int m_busy;   // hold cycles the model still owes

    // {pc_stall, if_id_stall, id_ex_bubble, if_id_flush, ex_hold, fwd_a, fwd_b, state}
    logic [10:0] obs;
    logic [10:0] exp_v;
    assign obs = {pc_stall, if_id_stall, id_ex_bubble, if_id_flush, ex_hold,
                  fwd_a_sel, fwd_b_sel, ctrl_state};

    hazard_ctrl #(.REG_AW(REG_AW), .MC_W(MC_W)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_uses_rq(id_uses_rq), .id_uses_rs(id_uses_rs),
        .id_rq_addr(id_rq_addr), .id_rs_addr(id_rs_addr),
        .ex_valid(ex_valid), .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load),
        .ex_rd_addr(ex_rd_addr), .ex_flush(ex_flush), .ex_mc_start(ex_mc_start),
        .ex_mc_len(ex_mc_len),
        .mem_valid(mem_valid), .mem_wr_en(mem_wr_en), .mem_rd_addr(mem_rd_addr),
        .wb_valid(wb_valid), .wb_wr_en(wb_wr_en), .wb_rd_addr(wb_rd_addr),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_bubble(id_ex_bubble),
        .if_id_flush(if_id_flush), .ex_hold(ex_hold),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .ctrl_state(ctrl_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] ref_fwd(input logic [REG_AW-1:0] src);
        if (mem_valid && mem_wr_en && mem_rd_addr == src) return 2'b01;
        if (wb_valid && wb_wr_en && wb_rd_addr == src) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [10:0] model_out();
        logic lu;
        logic ps, is, bb, fl, hd;
        logic [1:0] st;
        if (rst) return 11'd0;
        lu = id_valid && ex_valid && ex_is_load && ex_wr_en &&
             ((id_uses_rq && id_rq_addr == ex_rd_addr) ||
              (id_uses_rs && id_rs_addr == ex_rd_addr));
        ps = 0; is = 0; bb = 0; fl = 0; hd = 0; st = 2'b00;
        if (m_busy > 0) begin
            ps = 1; is = 1; hd = 1; st = 2'b01;
        end else if (ex_flush) begin
            fl = 1; bb = 1;
        end else if (lu) begin
            ps = 1; is = 1; bb = 1;
        end
        return {ps, is, bb, fl, hd, ref_fwd(id_rq_addr), ref_fwd(id_rs_addr), st};
    endfunction

    task automatic advance();
        @(posedge clk);
        if (rst) m_busy = 0;
        else if (m_busy > 0) m_busy = m_busy - 1;
        else if (ex_mc_start && !ex_flush && ex_mc_len != 0) m_busy = int'(ex_mc_len);
    endtask

    task automatic clear_inputs();
        id_valid = 0; id_uses_rq = 0; id_uses_rs = 0; id_rq_addr = 0; id_rs_addr = 0;
        ex_valid = 0; ex_wr_en = 0; ex_is_load = 0; ex_rd_addr = 0;
        ex_flush = 0; ex_mc_start = 0; ex_mc_len = 0;
        mem_valid = 0; mem_wr_en = 0; mem_rd_addr = 0;
        wb_valid = 0; wb_wr_en = 0; wb_rd_addr = 0;
    endtask

    task automatic set_load_use3();
        clear_inputs();
        id_valid = 1; id_uses_rq = 1; id_rq_addr = 3; id_rs_addr = 9;
        ex_valid = 1; ex_wr_en = 1; ex_is_load = 1; ex_rd_addr = 3;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1; m_busy = 0;
        clear_inputs();
        id_valid = 1; id_uses_rq = 1; id_rq_addr = 2; id_rs_addr = 2;
        ex_valid = 1; ex_wr_en = 1; ex_is_load = 1; ex_rd_addr = 2; ex_flush = 1;
        mem_valid = 1; mem_wr_en = 1; mem_rd_addr = 2;
        #1;
        n_checks++;
        if (obs !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want %b", obs, 11'd0);
        end
        advance();
        @(negedge clk);
        rst = 0;
        clear_inputs();
        #1;
        n_checks++;
        if (obs !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_release_idle: got %b want %b", obs, 11'd0);
        end
        advance();
    endtask

    task automatic test_load_use();
        @(negedge clk);
        set_load_use3();
        #1;
        n_checks++;
        if (obs[10:6] !== 5'b11100) begin
            n_fail++;
            $display("FAIL load_use_stall: got %b want %b", obs[10:6], 5'b11100);
        end
        advance();
        @(negedge clk);
        clear_inputs();
        id_valid = 1; id_uses_rq = 1; id_rq_addr = 3;
        mem_valid = 1; mem_wr_en = 1; mem_rd_addr = 3;
        #1;
        n_checks++;
        if (obs[10:4] !== 7'b0000001) begin
            n_fail++;
            $display("FAIL load_use_release: got %b want %b", obs[10:4], 7'b0000001);
        end
        advance();
    endtask

    task automatic test_flush();
        @(negedge clk);
        set_load_use3();
        ex_flush = 1;
        #1;
        n_checks++;
        if (obs[10:6] !== 5'b00110) begin
            n_fail++;
            $display("FAIL flush_over_lu: got %b want %b", obs[10:6], 5'b00110);
        end
        advance();
    endtask

    task automatic test_mc(input int len);
        int hold_cnt;
        int busy_cnt;
        hold_cnt = 0;
        busy_cnt = 0;
        @(negedge clk);
        clear_inputs();
        ex_valid = 1; ex_mc_start = 1; ex_mc_len = MC_W'(len);
        #1;
        n_checks++;
        if (ex_hold !== 1'b0 || ctrl_state !== 2'b00) begin
            n_fail++;
            $display("FAIL mc_start_cycle len=%0d: hold=%b state=%b want 0/00", len, ex_hold, ctrl_state);
        end
        advance();
        for (int i = 0; i < len + 3; i++) begin
            @(negedge clk);
            clear_inputs();
            if (m_busy > 0) begin
                // disturbances the busy FSM must ignore
                ex_flush = 1'($urandom_range(0, 1));
                ex_mc_start = 1; ex_mc_len = 4'd7;
                set_load_use3();
                ex_flush = 1'($urandom_range(0, 1));
            end
            #1;
            exp_v = model_out();
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL mc_cycle len=%0d i=%0d: got %b want %b", len, i, obs, exp_v);
            end
            hold_cnt += int'(ex_hold);
            busy_cnt += (ctrl_state == 2'b01) ? 1 : 0;
            advance();
        end
        n_checks++;
        if (hold_cnt != len || busy_cnt != len) begin
            n_fail++;
            $display("FAIL mc_hold_len len=%0d: hold=%0d busy=%0d want %0d", len, hold_cnt, busy_cnt, len);
        end
    endtask

    task automatic test_fwd();
        logic [1:0] want[4];
        want[0] = 2'b01; want[1] = 2'b10; want[2] = 2'b00; want[3] = 2'b01;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            clear_inputs();
            id_rq_addr = 5; id_rs_addr = 0;
            mem_valid = 1; mem_wr_en = (k != 1 && k != 2); mem_rd_addr = 5;
            wb_valid = 1; wb_wr_en = (k != 2); wb_rd_addr = (k == 3) ? 4'd0 : 4'd5;
            #1;
            n_checks++;
            if (fwd_a_sel !== want[k]) begin
                n_fail++;
                $display("FAIL fwd_a k=%0d: got %b want %b", k, fwd_a_sel, want[k]);
            end
            if (k == 3) begin
                n_checks++;
                if (fwd_b_sel !== 2'b10) begin
                    n_fail++;
                    $display("FAIL fwd_b_reg0: got %b want %b", fwd_b_sel, 2'b10);
                end
            end
            advance();
        end
    endtask

    task automatic test_reset_mid_mc();
        @(negedge clk);
        clear_inputs();
        ex_mc_start = 1; ex_mc_len = 5;
        advance();
        @(negedge clk);
        clear_inputs();
        advance();
        @(negedge clk);
        mem_valid = 1; mem_wr_en = 1; mem_rd_addr = 0;
        n_checks++;
        if (ctrl_state !== 2'b01) begin
            n_fail++;
            $display("FAIL rst_mc_pre: state=%b want 01", ctrl_state);
        end
        rst = 1; m_busy = 0;
        #1;
        n_checks++;
        if (obs !== 11'd0) begin
            n_fail++;
            $display("FAIL rst_mc_outputs: got %b want %b", obs, 11'd0);
        end
        advance();
        @(negedge clk);
        rst = 0;
        clear_inputs();
        for (int i = 0; i < 6; i++) begin
            #1;
            n_checks++;
            if (ex_hold !== 1'b0 || ctrl_state !== 2'b00 || pc_stall !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_mc_residual i=%0d: hold=%b state=%b stall=%b want 0", i, ex_hold, ctrl_state, pc_stall);
            end
            advance();
            @(negedge clk);
        end
    endtask

    task automatic test_mc_flush();
        @(negedge clk);
        clear_inputs();
        ex_valid = 1; ex_mc_start = 1; ex_mc_len = 3; ex_flush = 1;
        #1;
        n_checks++;
        if (obs[10:6] !== 5'b00110 || ctrl_state !== 2'b00) begin
            n_fail++;
            $display("FAIL mc_flush_same: got %b state=%b want 00110/00", obs[10:6], ctrl_state);
        end
        advance();
        @(negedge clk);
        clear_inputs();
        #1;
        n_checks++;
        if (ctrl_state !== 2'b00 || ex_hold !== 1'b0) begin
            n_fail++;
            $display("FAIL mc_flush_after: state=%b hold=%b want 00/0", ctrl_state, ex_hold);
        end
        advance();
    endtask

    task automatic test_random(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            id_valid = 1'($urandom_range(0, 1)); id_uses_rq = 1'($urandom_range(0, 1));
            id_uses_rs = 1'($urandom_range(0, 1));
            id_rq_addr = 4'($urandom_range(0, 3)); id_rs_addr = 4'($urandom_range(0, 3));
            ex_valid = 1'($urandom_range(0, 1)); ex_wr_en = 1'($urandom_range(0, 1));
            ex_is_load = 1'($urandom_range(0, 1)); ex_rd_addr = 4'($urandom_range(0, 3));
            ex_flush = ($urandom_range(0, 7) == 0);
            ex_mc_start = ($urandom_range(0, 5) == 0);
            ex_mc_len = 4'($urandom_range(0, 4));
            mem_valid = 1'($urandom_range(0, 1)); mem_wr_en = 1'($urandom_range(0, 1));
            mem_rd_addr = 4'($urandom_range(0, 3));
            wb_valid = 1'($urandom_range(0, 1)); wb_wr_en = 1'($urandom_range(0, 1));
            wb_rd_addr = 4'($urandom_range(0, 3));
            #1;
            exp_v = model_out();
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL random i=%0d: got %b want %b", i, obs, exp_v);
            end
            advance();
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_busy   = 0;
        rst      = 1;
        clear_inputs();
        test_reset();
        test_load_use();
        test_flush();
        test_mc(3);
        test_mc(0);
        test_mc(1);
        test_fwd();
        test_reset_mid_mc();
        test_mc_flush();
        test_random(400);
        test_mc(15);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
